emif_avmm_drain_gate: RTL

//  Per-bank AVMM gate between the AFU-facing DDR port and the EMIF-side pipeline bridge.

---
 rtl/emif_avmm_drain_gate.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/emif_avmm_drain_gate.sv
// emif_avmm_drain_gate: per-bank AVMM gate that drains open write bursts and
// outstanding read beats before acknowledging a freeze. It also enforces a
// read-beat credit limit and flags drains that overrun a cycle budget.
module emif_avmm_drain_gate #(
  parameter int ADDR_WIDTH       = 27,
  parameter int DATA_WIDTH       = 512,
  parameter int BURSTCOUNT_WIDTH = 7,
  parameter int MAX_RD_BEATS     = 64,
  parameter int DRAIN_TIMEOUT    = 4096
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              freeze_req,
  output logic                              freeze_ack,
  output logic                              drain_timeout_err,
  output logic [$clog2(MAX_RD_BEATS+1)-1:0] rd_beats_pending,
  input  logic                              s_read,
  input  logic                              s_write,
  input  logic [ADDR_WIDTH-1:0]             s_address,
  input  logic [BURSTCOUNT_WIDTH-1:0]       s_burstcount,
  input  logic [DATA_WIDTH-1:0]             s_writedata,
  input  logic [DATA_WIDTH/8-1:0]           s_byteenable,
  output logic                              s_waitrequest,
  output logic [DATA_WIDTH-1:0]             s_readdata,
  output logic                              s_readdatavalid,
  output logic                              m_read,
  output logic                              m_write,
  output logic [ADDR_WIDTH-1:0]             m_address,
  output logic [BURSTCOUNT_WIDTH-1:0]       m_burstcount,
  output logic [DATA_WIDTH-1:0]             m_writedata,
  output logic [DATA_WIDTH/8-1:0]           m_byteenable,
  input  logic                              m_waitrequest,
  input  logic [DATA_WIDTH-1:0]             m_readdata,
  input  logic                              m_readdatavalid
);

  localparam int PW = $clog2(MAX_RD_BEATS + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  // Wide enough to hold pending + burstcount without wrapping.
  localparam int SW = ((PW > BURSTCOUNT_WIDTH) ? PW : BURSTCOUNT_WIDTH) + 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FROZEN} state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [BURSTCOUNT_WIDTH-1:0] r_wr_left;
  logic [PW-1:0]               r_rd_pending;
  logic [TW-1:0]               r_timer;
  logic                        r_freeze_ack;
  logic                        r_timeout_err;

  logic [BURSTCOUNT_WIDTH-1:0] w_bc;
  logic [SW-1:0]               w_rd_sum;
  logic                        w_rd_ok;
  logic                        w_wr_ok;
  logic                        w_rd_acc;
  logic                        w_wr_acc;
  logic                        w_drained;
  logic                        w_timeout;
  logic                        w_timeout_fire;
  logic                        w_rd_dec;
  logic [PW-1:0]               w_rd_pending_next;

  // Datapath is a zero-latency pass-through; only handshakes are gated.
  assign m_address         = s_address;
  assign m_burstcount      = s_burstcount;
  assign m_writedata       = s_writedata;
  assign m_byteenable      = s_byteenable;
  assign s_readdata        = m_readdata;
  assign s_readdatavalid   = m_readdatavalid;
  assign freeze_ack        = r_freeze_ack;
  assign drain_timeout_err = r_timeout_err;
  assign rd_beats_pending  = r_rd_pending;

  // A burstcount of zero is treated as a single beat.
  assign w_bc     = (s_burstcount == '0) ? BURSTCOUNT_WIDTH'(1) : s_burstcount;
  assign w_rd_sum = SW'(r_rd_pending) + SW'(w_bc);

  // New reads only start in RUN, outside a write burst, and within the credit limit.
  assign w_rd_ok = (r_state == ST_RUN) && (r_wr_left == '0) &&
                   (w_rd_sum <= SW'(MAX_RD_BEATS));
  // Remaining beats of an open write burst always pass so the burst completes.
  assign w_wr_ok = (r_state == ST_RUN) || ((r_wr_left != '0) && (r_state != ST_FROZEN));

  assign w_rd_acc       = m_read  & ~m_waitrequest;
  assign w_wr_acc       = m_write & ~m_waitrequest;
  assign w_drained      = (r_wr_left == '0) && (r_rd_pending == '0);
  assign w_timeout      = (r_state == ST_DRAIN) && (r_timer == TW'(DRAIN_TIMEOUT - 1));
  assign w_timeout_fire = w_timeout && freeze_req && !w_drained;

  // A stray readdatavalid with nothing in flight must not underflow.
  assign w_rd_dec          = m_readdatavalid && (w_rd_acc || (r_rd_pending != '0));
  assign w_rd_pending_next = r_rd_pending + (w_rd_acc ? PW'(w_bc) : '0) - PW'(w_rd_dec);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_next;
  end

  // FSM next-state: drain on request, freeze once empty or out of time.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:    if (freeze_req) w_state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (!freeze_req)    w_state_next = ST_RUN;
        else if (w_drained) w_state_next = ST_FROZEN;
        else if (w_timeout) w_state_next = ST_FROZEN;
      end
      ST_FROZEN: if (!freeze_req) w_state_next = ST_RUN;
      default:   w_state_next = ST_RUN;
    endcase
  end

  // FSM outputs: gated commands and the AFU-side stall.
  always_comb begin
    m_read        = s_read  & w_rd_ok;
    m_write       = s_write & w_wr_ok;
    s_waitrequest = m_waitrequest | (s_read & ~w_rd_ok) | (s_write & ~w_wr_ok) |
                    (r_state == ST_FROZEN);
  end

  // Burst and credit tracking; a drain timeout discards the now-stale counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_left    <= '0;
      r_rd_pending <= '0;
    end else if (w_timeout_fire) begin
      r_wr_left    <= '0;
      r_rd_pending <= '0;
    end else begin
      if (w_wr_acc) begin
        if (r_wr_left == '0) r_wr_left <= w_bc - BURSTCOUNT_WIDTH'(1);
        else                 r_wr_left <= r_wr_left - BURSTCOUNT_WIDTH'(1);
      end
      r_rd_pending <= w_rd_pending_next;
    end
  end

  // Drain timer, registered ack and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer       <= '0;
      r_freeze_ack  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timer       <= (r_state == ST_DRAIN) ? r_timer + TW'(1) : '0;
      r_freeze_ack  <= (w_state_next == ST_FROZEN);
      r_timeout_err <= r_timeout_err | w_timeout_fire;
    end
  end

endmodule
